// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the program loader.
// The slave view belongs to the loader; the master view belongs to the stream source and observer.
interface imem_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        start;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   modport slave (
      input  in_data, in_valid, start,
      output in_ready, imem_we, imem_addr, imem_wdata,
      output cpu_hold, done, error, words_loaded
   );

   modport master (
      output in_data, in_valid, start,
      input  in_ready, imem_we, imem_addr, imem_wdata,
      input  cpu_hold, done, error, words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a checksummed little-endian byte stream into 32-bit words,
// writes them to instruction memory and keeps the core in reset until the load verifies.
module imem_loader #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          areset,
   imem_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_HDR_LO,
      S_HDR_HI,
      S_LOAD,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t      r_state;
   logic [15:0] r_count;
   logic [7:0]  r_csum;
   logic [1:0]  r_bcnt;
   logic [23:0] r_word;
   logic        r_ready;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_hold;
   logic        r_done;
   logic        r_err;
   logic [15:0] r_words;

   logic        w_acc;
   logic [15:0] w_count_full;
   logic [7:0]  w_csum_nxt;
   logic [15:0] w_words_nxt;
   logic [31:0] w_addr_nxt;

   assign w_acc        = bus.in_valid & r_ready;
   assign w_count_full = {bus.in_data, r_count[7:0]};
   assign w_csum_nxt   = r_csum ^ bus.in_data;
   assign w_words_nxt  = r_words + 16'd1;
   assign w_addr_nxt   = BASE_ADDR + 32'({r_words, 2'b00});

   assign bus.in_ready     = r_ready;
   assign bus.imem_we      = r_we;
   assign bus.imem_addr    = r_addr;
   assign bus.imem_wdata   = r_wdata;
   assign bus.cpu_hold     = r_hold;
   assign bus.done         = r_done;
   assign bus.error        = r_err;
   assign bus.words_loaded = r_words;

   // Load sequencer; in_ready is high exactly in the states that consume bytes.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         r_state <= S_HDR_LO;
         r_count <= 16'd0;
         r_csum  <= 8'd0;
         r_bcnt  <= 2'd0;
         r_word  <= 24'd0;
         r_ready <= 1'b1;
         r_we    <= 1'b0;
         r_addr  <= BASE_ADDR;
         r_wdata <= 32'd0;
         r_hold  <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_words <= 16'd0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_HDR_LO: begin
               if (w_acc) begin
                  r_count[7:0] <= bus.in_data;
                  r_csum       <= w_csum_nxt;
                  r_state      <= S_HDR_HI;
               end
            end
            S_HDR_HI: begin
               if (w_acc) begin
                  r_count[15:8] <= bus.in_data;
                  r_csum        <= w_csum_nxt;
                  if (32'(w_count_full) > DEPTH_WORDS) begin
                     r_state <= S_ERR;
                     r_ready <= 1'b0;
                     r_err   <= 1'b1;
                  end else if (w_count_full == 16'd0) begin
                     r_state <= S_CHK;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (w_acc) begin
                  r_csum <= w_csum_nxt;
                  r_bcnt <= r_bcnt + 2'd1;
                  case (r_bcnt)
                     2'd0: r_word[7:0]   <= bus.in_data;
                     2'd1: r_word[15:8]  <= bus.in_data;
                     2'd2: r_word[23:16] <= bus.in_data;
                     default: begin
                        r_wdata <= {bus.in_data, r_word};
                        r_addr  <= w_addr_nxt;
                        r_we    <= 1'b1;
                        r_words <= w_words_nxt;
                        if (w_words_nxt == r_count) r_state <= S_CHK;
                     end
                  endcase
               end
            end
            S_CHK: begin
               if (w_acc) begin
                  r_ready <= 1'b0;
                  if (bus.in_data == r_csum) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_hold  <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               // Restart keeps memory contents; only loader bookkeeping is cleared.
               if (bus.start) begin
                  r_state <= S_HDR_LO;
                  r_csum  <= 8'd0;
                  r_bcnt  <= 2'd0;
                  r_words <= 16'd0;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_hold  <= 1'b1;
                  r_ready <= 1'b1;
               end
            end
            default: r_state <= S_HDR_LO;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk    = 1'b0;
   logic areset = 1'b0;

   imem_loader_if bus ();

   imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk    (clk),
      .areset (areset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   logic [7:0]  stim[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic        exp_done;
   logic [15:0] exp_words;

   logic [31:0] mon_addr[$];
   logic [31:0] mon_data[$];
   logic [15:0] mon_wl[$];
   time         mon_t[$];
   time         acc_t[$];

   // Record every write strobe seen between clock edges.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         mon_addr.push_back(bus.imem_addr);
         mon_data.push_back(bus.imem_wdata);
         mon_wl.push_back(bus.words_loaded);
         mon_t.push_back($time);
         check("hold_while_writing", 32'(bus.cpu_hold), 32'd1);
      end
   end

   // Interpret the whole stream: header count, payload words, XOR checksum.
   task automatic model();
      int unsigned n;
      logic [7:0]  x;
      logic [31:0] w;
      exp_addr.delete();
      exp_data.delete();
      n = {stim[1], stim[0]};
      x = stim[0] ^ stim[1];
      if (n > DEPTH) begin
         exp_done  = 1'b0;
         exp_words = 16'd0;
         return;
      end
      for (int i = 0; i < int'(n); i++) begin
         w = 32'd0;
         for (int b = 0; b < 4; b++) begin
            w = w | (32'(stim[2 + 4*i + b]) << (8*b));
            x = x ^ stim[2 + 4*i + b];
         end
         exp_addr.push_back(BASE + 32'(4*i));
         exp_data.push_back(w);
      end
      exp_words = 16'(n);
      exp_done  = (stim[2 + 4*n] == x);
   endtask

   task automatic clear_mon();
      mon_addr.delete();
      mon_data.delete();
      mon_wl.delete();
      mon_t.delete();
      acc_t.delete();
   endtask

   // Drive the first cnt bytes of stim; returns right after the last accepting edge.
   task automatic send_n(input int cnt, input int gap_max);
      int t;
      for (int i = 0; i < cnt; i++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = stim[i];
         t = 0;
         while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         acc_t.push_back($time);
      end
   endtask

   task automatic run_case(input string name, input int gap_max);
      int nw;
      model();
      clear_mon();
      send_n(stim.size(), gap_max);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({name, "_done_next"},  32'(bus.done),     32'(exp_done));
      check({name, "_error_next"}, 32'(bus.error),    32'(!exp_done));
      check({name, "_hold_next"},  32'(bus.cpu_hold), 32'(!exp_done));
      repeat (3) @(negedge clk);
      check({name, "_nwrites"}, 32'(mon_addr.size()), 32'(exp_addr.size()));
      nw = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
      for (int i = 0; i < nw; i++) begin
         check($sformatf("%s_addr%0d", name, i), mon_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", name, i), mon_data[i], exp_data[i]);
         check($sformatf("%s_wl%0d", name, i), 32'(mon_wl[i]), 32'(i + 1));
         check($sformatf("%s_lat%0d", name, i), 32'(mon_t[i] - acc_t[2 + 4*i + 3]), 32'd5);
      end
      check({name, "_words"}, 32'(bus.words_loaded), 32'(exp_words));
      check({name, "_done"},  32'(bus.done),         32'(exp_done));
      check({name, "_error"}, 32'(bus.error),        32'(!exp_done));
      check({name, "_hold"},  32'(bus.cpu_hold),     32'(!exp_done));
      check({name, "_ready"}, 32'(bus.in_ready),     32'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_hold",  32'(bus.cpu_hold),     32'd1);
      check("start_done",  32'(bus.done),         32'd0);
      check("start_error", 32'(bus.error),        32'd0);
      check("start_ready", 32'(bus.in_ready),     32'd1);
      check("start_words", 32'(bus.words_loaded), 32'd0);
   endtask

   task automatic load_stream1(input logic [7:0] ck);
      stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
      stim.push_back(ck);
   endtask

   task automatic build_random(input int unsigned n, input bit bad);
      logic [7:0] x;
      logic [7:0] b;
      stim.delete();
      stim.push_back(n[7:0]);
      stim.push_back(n[15:8]);
      x = n[7:0] ^ n[15:8];
      if (n > DEPTH) return;
      for (int i = 0; i < int'(4*n); i++) begin
         b = 8'($urandom);
         stim.push_back(b);
         x = x ^ b;
      end
      stim.push_back(bad ? (x ^ 8'($urandom_range(255, 1))) : x);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      bus.start    = 1'b0;
      repeat (2) @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(bus.in_ready),     32'd1);
      check("rst_we",    32'(bus.imem_we),      32'd0);
      check("rst_addr",  bus.imem_addr,         BASE);
      check("rst_wdata", bus.imem_wdata,        32'd0);
      check("rst_hold",  32'(bus.cpu_hold),     32'd1);
      check("rst_done",  32'(bus.done),         32'd0);
      check("rst_error", 32'(bus.error),        32'd0);
      check("rst_words", 32'(bus.words_loaded), 32'd0);

      load_stream1(8'hC3);
      run_case("s1", 0);
      check("s1_word0_const", (mon_data.size() > 0) ? mon_data[0] : 32'hX, 32'h0050_0093);
      check("s1_word1_const", (mon_data.size() > 1) ? mon_data[1] : 32'hX, 32'h0010_0113);

      pulse_start();
      load_stream1(8'hC2);
      run_case("s1_badck", 0);

      pulse_start();
      stim = '{8'h41, 8'h00};
      run_case("hdr_over", 0);

      pulse_start();
      stim = '{8'h00, 8'h00, 8'h00};
      run_case("n0", 0);

      pulse_start();
      load_stream1(8'hC3);
      run_case("s1_gaps", 3);

      for (int k = 0; k < 6; k++) begin
         int unsigned n;
         n = (k == 0) ? DEPTH : (k == 1) ? DEPTH + 1 + $urandom_range(100, 0) : $urandom_range(8, 1);
         pulse_start();
         build_random(n, ($urandom_range(2, 0) == 0));
         run_case($sformatf("rnd%0d", k), (k % 2 == 0) ? 0 : 2);
      end

      // Reset in the middle of a load, right as the first word's strobe is issued.
      pulse_start();
      load_stream1(8'hC3);
      clear_mon();
      send_n(6, 0);
      #2;
      bus.in_valid = 1'b0;
      areset = 1'b0;
      #1;
      check("midrst_we",    32'(bus.imem_we),      32'd0);
      check("midrst_words", 32'(bus.words_loaded), 32'd0);
      check("midrst_hold",  32'(bus.cpu_hold),     32'd1);
      @(negedge clk);
      areset = 1'b1;
      run_case("s1_after_rst", 1);
      pulse_start();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory of the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them to the instruction memory's write port. While loading, it holds the processor in reset through `cpu_hold`, and releases the core only after the stream's checksum verifies.

## Interface
- `DEPTH_WORDS`, default 64: instruction memory capacity in words; larger counts are rejected.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first written word; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `areset` in 1: reset, asynchronous and active-low.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a byte.
- `start` in 1: one-cycle pulse; restarts a load from DONE or ERR.
- `imem_we` out 1: instruction memory write enable, one-cycle pulse per word.
- `imem_addr` out 32: byte address of the write, word-aligned, PC-style.
- `imem_wdata` out 32: word to write.
- `cpu_hold` out 1: high keeps the processor in reset.
- `done` out 1: load completed, checksum good.
- `error` out 1: load failed.
- `words_loaded` out 16: number of words written in the current load.

## Operation
- Stream format: count low byte, count high byte (16-bit word count N), then 4·N payload bytes, then one checksum byte. Payload bytes arrive LSB first per word.
- Checksum: XOR of all bytes before it, header bytes included.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- States:
  - **HDR_LO**: capture count[7:0] and go to HDR_HI.
  - **HDR_HI**: capture count[15:8].
    - count > `DEPTH_WORDS` → ERR.
    - count == 0 → CHK.
    - Otherwise → LOAD.
  - **LOAD**: a 2-bit byte counter fills the word at bit position 8·k.
    - On acceptance of byte 3, register the assembled word and address `BASE_ADDR + 4·words_loaded`, assert `imem_we` for the next cycle, and increment `words_loaded`.
    - After word N is written → CHK.
  - **CHK**: accepted byte equal to the running XOR → DONE, otherwise → ERR.
  - **DONE**: `in_ready`=0, `done`=1, `cpu_hold`=0.
  - **ERR**: `in_ready`=0, `error`=1, `cpu_hold`=1.
- `start` in DONE or ERR → HDR_LO. This clears the checksum, `words_loaded`, `done`, `error` and the byte counter, and sets `cpu_hold`=1. `start` is ignored in all other states.
- `in_ready`=1 in HDR_LO, HDR_HI, LOAD and CHK; writes never stall the stream.
- Memory contents written before an ERR are left in place; the core stays held.

## Timing
- Reset (async assert) values: state HDR_LO, `in_ready`=1 after reset release, `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `words_loaded`=0, checksum=0.
- Reset mid-load discards any partial word and the count; loading restarts from HDR_LO.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered and valid in the cycle after the edge that accepted the word's 4th byte. `imem_we` is high for exactly one cycle.
- Back-to-back bytes give at most one write every 4 cycles. Byte 0 of the next word may be accepted in the same cycle that `imem_we` is high.
- `words_loaded` updates on the same edge that raises `imem_we`.
- DONE/ERR outputs are registered and take effect the cycle after the checksum byte is accepted. `cpu_hold` falls in that same cycle.
- `in_valid` low stalls indefinitely with no state change. Gaps between bytes of a word are legal.
- `start` arriving on the same edge as a checksum byte is ignored, because the state is CHK at that edge.

## Test plan
- Stream 02 00 93 00 50 00 13 01 10 00 C3, `in_valid` held high:
  - Write 0x00500093 @0x0, then 0x00100113 @0x4.
  - `words_loaded`=2, `done`=1, `cpu_hold`=0.
  - `imem_we` is high for exactly 2 cycles.
- Same stream with last byte C2 → both writes occur, then `error`=1, `cpu_hold`=1, `in_ready`=0.
- Header 41 00 with `DEPTH_WORDS`=64 (N=65) → ERR the cycle after the 2nd byte, no `imem_we`.
- Stream 00 00 00 (N=0, checksum 0x00) → `done`=1, no writes, `words_loaded`=0.
- Random `in_valid` gaps during the first stream → identical writes and final state; no byte lost or duplicated.
- Reset asserted after 6 bytes, then released and the full first stream resent → only the two correct writes after the release, then `done`=1. Then pulse `start` → `cpu_hold`=1, `done`=0, `in_ready`=1.
